// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 16x oversampling with 3-sample majority vote, parity/framing/break
// detection, and a one-entry valid/ready output register with sticky overrun.
module uart_rx_cfg #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_perr,
    output logic                 m_ferr,
    output logic                 m_brk,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 overrun,
    input  logic                 ovr_clr,
    output logic                 busy
);
    localparam int DIV   = (CLK_FREQ_HZ + 8 * BAUD_RATE) / (16 * BAUD_RATE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_WAIT   = 3'd5;

    generate
        if (DIV < 2) begin : g_badDiv
            $error("uart_rx_cfg: round(CLK_FREQ_HZ/(16*BAUD_RATE)) must be at least 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_badData
            $error("uart_rx_cfg: DATA_BITS must be 5..9");
        end
        if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_badParity
            $error("uart_rx_cfg: PARITY_MODE must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_badStop
            $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
        end
    endgenerate

    logic                 r_rxMeta;
    logic                 r_rxSync;
    logic                 w_rxS;
    logic [2:0]           r_state;
    logic [DIV_W-1:0]     r_divCnt;
    logic [3:0]           r_subCnt;
    logic [3:0]           r_bitCnt;
    logic                 r_stopCnt;
    logic                 r_samp7;
    logic                 r_samp8;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_allZero;

    logic w_tick;
    logic w_decide;
    logic w_bitEnd;
    logic w_bit;
    logic w_parExp;
    logic w_lastStop;
    logic w_done;
    logic w_ferrFinal;
    logic w_brkFinal;
    logic w_load;
    logic w_drop;

    // Synchroniser resets to idle-high so reset release never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rxMeta <= 1'b1;
            r_rxSync <= 1'b1;
        end else begin
            r_rxMeta <= rx;
            r_rxSync <= r_rxMeta;
        end
    end

    assign w_rxS = r_rxSync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_divCnt <= '0;
            r_subCnt <= '0;
        end else if (r_state == S_IDLE || r_state == S_WAIT) begin
            r_divCnt <= '0;
            r_subCnt <= '0;
        end else if (w_tick) begin
            r_divCnt <= '0;
            r_subCnt <= r_subCnt + 4'd1;
        end else begin
            r_divCnt <= r_divCnt + DIV_W'(1);
        end
    end

    assign w_tick     = (r_divCnt == DIV_W'(DIV - 1));
    assign w_decide   = w_tick && (r_subCnt == 4'd9);
    assign w_bitEnd   = w_tick && (r_subCnt == 4'd15);
    assign w_bit      = (r_samp7 & r_samp8) | (r_samp7 & w_rxS) | (r_samp8 & w_rxS);
    assign w_parExp   = (PARITY_MODE == 2) ? ~(^r_shift) : (^r_shift);
    assign w_lastStop = (r_stopCnt == 1'(STOP_BITS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_samp7 <= 1'b1;
            r_samp8 <= 1'b1;
        end else begin
            if (w_tick && r_subCnt == 4'd7) r_samp7 <= w_rxS;
            if (w_tick && r_subCnt == 4'd8) r_samp8 <= w_rxS;
        end
    end

    // The frame finishes on the last stop-bit decision, half a bit early, so a short stop still resyncs.
    assign w_done      = (r_state == S_STOP) && w_decide && w_lastStop;
    assign w_ferrFinal = r_ferr | ~w_bit;
    assign w_brkFinal  = r_allZero & ~w_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_bitCnt  <= '0;
            r_stopCnt <= 1'b0;
            r_shift   <= '0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_allZero <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_rxS) begin
                        r_state   <= S_START;
                        r_bitCnt  <= '0;
                        r_stopCnt <= 1'b0;
                        r_perr    <= 1'b0;
                        r_ferr    <= 1'b0;
                        r_allZero <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_decide && w_bit) begin
                        r_state <= S_IDLE;
                    end else if (w_bitEnd) begin
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_decide) begin
                        r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
                        r_bitCnt  <= r_bitCnt + 4'd1;
                        r_allZero <= r_allZero & ~w_bit;
                    end
                    if (w_bitEnd && r_bitCnt == 4'(DATA_BITS)) begin
                        r_bitCnt <= '0;
                        r_state  <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    if (w_decide) begin
                        r_perr    <= (w_bit != w_parExp);
                        r_allZero <= r_allZero & ~w_bit;
                    end
                    if (w_bitEnd) begin
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_decide) begin
                        r_ferr    <= w_ferrFinal;
                        r_allZero <= w_brkFinal;
                        if (w_lastStop) begin
                            r_state <= w_ferrFinal ? S_WAIT : S_IDLE;
                        end else begin
                            r_stopCnt <= r_stopCnt + 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (w_rxS) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_load = w_done && (!m_valid || m_ready);
    assign w_drop = w_done && m_valid && !m_ready;

    // A full register with no taker keeps its word; the new frame is lost and flagged instead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data  <= '0;
            m_perr  <= 1'b0;
            m_ferr  <= 1'b0;
            m_brk   <= 1'b0;
            m_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (w_load) begin
                m_data  <= r_shift;
                m_perr  <= r_perr;
                m_ferr  <= w_ferrFinal;
                m_brk   <= w_brkFinal;
                m_valid <= 1'b1;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
            if (w_drop) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: four receiver configurations sharing one clock, each fed by a
// behavioural serial transmitter, with outputs captured on handshake and compared to hand values.
`timescale 1ns/1ps
module tb_uart_rx_cfg;
    localparam int  CLK_HZ = 1_600_000;
    localparam int  BAUD   = 25_000;
    localparam real BIT_NS = 640.0;

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } outRec_t;

    typedef struct {
        int         dut;
        logic [8:0] data;
        bit         parFlip;
        bit         stopVal;
        real        bitNs;
        logic [8:0] expData;
        bit         expPerr;
        bit         expFerr;
        bit         expBrk;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxLine[4];
    logic       mReady[4];
    logic       ovrClr[4];
    logic       mValid[4];
    logic       mPerr[4];
    logic       mFerr[4];
    logic       mBrk[4];
    logic       overrun[4];
    logic       busy[4];
    logic [7:0] mData0;
    logic [7:0] mData1;
    logic [4:0] mData2;
    logic [8:0] mData3;

    int checks = 0;
    int fails  = 0;
    int run0    = 0;
    int maxRun0 = 0;

    outRec_t q0[$];
    outRec_t q1[$];
    outRec_t q2[$];
    outRec_t q3[$];
    vec_t    vecs[14];

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD)) u0 (
        .clk(clk), .rst(rst), .rx(rxLine[0]), .m_data(mData0), .m_perr(mPerr[0]),
        .m_ferr(mFerr[0]), .m_brk(mBrk[0]), .m_valid(mValid[0]), .m_ready(mReady[0]),
        .overrun(overrun[0]), .ovr_clr(ovrClr[0]), .busy(busy[0]));

    uart_rx_cfg #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .PARITY_MODE(1)) u1 (
        .clk(clk), .rst(rst), .rx(rxLine[1]), .m_data(mData1), .m_perr(mPerr[1]),
        .m_ferr(mFerr[1]), .m_brk(mBrk[1]), .m_valid(mValid[1]), .m_ready(mReady[1]),
        .overrun(overrun[1]), .ovr_clr(ovrClr[1]), .busy(busy[1]));

    uart_rx_cfg #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(5), .STOP_BITS(2)) u2 (
        .clk(clk), .rst(rst), .rx(rxLine[2]), .m_data(mData2), .m_perr(mPerr[2]),
        .m_ferr(mFerr[2]), .m_brk(mBrk[2]), .m_valid(mValid[2]), .m_ready(mReady[2]),
        .overrun(overrun[2]), .ovr_clr(ovrClr[2]), .busy(busy[2]));

    uart_rx_cfg #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(9), .PARITY_MODE(2)) u3 (
        .clk(clk), .rst(rst), .rx(rxLine[3]), .m_data(mData3), .m_perr(mPerr[3]),
        .m_ferr(mFerr[3]), .m_brk(mBrk[3]), .m_valid(mValid[3]), .m_ready(mReady[3]),
        .overrun(overrun[3]), .ovr_clr(ovrClr[3]), .busy(busy[3]));

    function automatic int cfgBits(input int d);
        case (d)
            2:       return 5;
            3:       return 9;
            default: return 8;
        endcase
    endfunction

    function automatic int cfgPar(input int d);
        case (d)
            1:       return 1;
            3:       return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int cfgStop(input int d);
        return (d == 2) ? 2 : 1;
    endfunction

    function automatic logic [8:0] getData(input int d);
        case (d)
            0:       return {1'b0, mData0};
            1:       return {1'b0, mData1};
            2:       return {4'b0, mData2};
            default: return mData3;
        endcase
    endfunction

    function automatic int qSize(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            2:       return q2.size();
            default: return q3.size();
        endcase
    endfunction

    function automatic outRec_t qPop(input int d);
        case (d)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            2:       return q2.pop_front();
            default: return q3.pop_front();
        endcase
    endfunction

    // Every accepted word is queued per receiver; the run counter measures m_valid pulse width.
    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (mValid[d] && mReady[d]) begin
                outRec_t r;
                r.data = getData(d);
                r.perr = mPerr[d];
                r.ferr = mFerr[d];
                r.brk  = mBrk[d];
                case (d)
                    0:       q0.push_back(r);
                    1:       q1.push_back(r);
                    2:       q2.push_back(r);
                    default: q3.push_back(r);
                endcase
            end
        end
        if (mValid[0]) run0 = run0 + 1;
        else           run0 = 0;
        if (run0 > maxRun0) maxRun0 = run0;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic setRx(input int d, input logic v);
        rxLine[d] = v;
    endtask

    task automatic sendFrame(input int d, input logic [8:0] data, input bit parFlip,
                             input bit stopVal, input real bitNs);
        logic p;
        p = 1'b0;
        setRx(d, 1'b0);
        #(bitNs);
        for (int i = 0; i < cfgBits(d); i++) begin
            setRx(d, data[i]);
            p = p ^ data[i];
            #(bitNs);
        end
        if (cfgPar(d) != 0) begin
            setRx(d, ((cfgPar(d) == 2) ? ~p : p) ^ parFlip);
            #(bitNs);
        end
        for (int i = 0; i < cfgStop(d); i++) begin
            setRx(d, stopVal);
            #(bitNs);
        end
        setRx(d, 1'b1);
    endtask

    task automatic checkFrame(input string name, input int d, input logic [8:0] expData,
                              input bit ePerr, input bit eFerr, input bit eBrk);
        outRec_t r;
        int      n;
        n = qSize(d);
        checkOutput({name, " count"}, 32'(n), 32'd1);
        if (n > 0) begin
            r = qPop(d);
            checkOutput({name, " data"}, 32'(r.data), 32'(expData));
            checkOutput({name, " perr"}, 32'(r.perr), 32'(ePerr));
            checkOutput({name, " ferr"}, 32'(r.ferr), 32'(eFerr));
            checkOutput({name, " brk"},  32'(r.brk),  32'(eBrk));
        end
        while (qSize(d) > 0) r = qPop(d);
    endtask

    task automatic applyStimulus(input vec_t v);
        sendFrame(v.dut, v.data, v.parFlip, v.stopVal, v.bitNs);
        #(2.0 * BIT_NS);
    endtask

    task automatic resetMidFrame(input string name, input int d, input logic [8:0] expData);
        fork
            sendFrame(d, 9'h096, 1'b0, 1'b1, BIT_NS);
            begin
                #(5.5 * BIT_NS);
                @(posedge clk);
                #1;
                checkOutput({name, " busy before reset"}, 32'(busy[d]), 32'd1);
                rst = 1'b1;
                @(negedge clk);
                checkOutput({name, " rst busy"},    32'(busy[d]),    32'd0);
                checkOutput({name, " rst valid"},   32'(mValid[d]),  32'd0);
                checkOutput({name, " rst data"},    32'(getData(d)), 32'd0);
                checkOutput({name, " rst flags"},   32'({mPerr[d], mFerr[d], mBrk[d]}), 32'd0);
                checkOutput({name, " rst overrun"}, 32'(overrun[d]), 32'd0);
            end
        join
        #(BIT_NS);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #(2.0 * BIT_NS);
        checkOutput({name, " aborted frame output"}, 32'(qSize(d)), 32'd0);
        sendFrame(d, 9'h096, 1'b0, 1'b1, BIT_NS);
        #(2.0 * BIT_NS);
        checkFrame({name, " after reset"}, d, expData, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        //            dut  data     flip  stop  bitNs          expData  perr  ferr  brk
        vecs[0]  = '{0, 9'h0A5, 1'b0, 1'b1, BIT_NS,        9'h0A5, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{0, 9'h000, 1'b0, 1'b1, BIT_NS,        9'h000, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{0, 9'h0FF, 1'b0, 1'b1, BIT_NS,        9'h0FF, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{0, 9'h05A, 1'b0, 1'b1, BIT_NS,        9'h05A, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{0, 9'h0C3, 1'b0, 1'b1, BIT_NS / 1.03, 9'h0C3, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{0, 9'h0C3, 1'b0, 1'b1, BIT_NS / 0.97, 9'h0C3, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1, 9'h007, 1'b1, 1'b1, BIT_NS,        9'h007, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1, 9'h007, 1'b0, 1'b1, BIT_NS,        9'h007, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1, 9'h03C, 1'b0, 1'b0, BIT_NS,        9'h03C, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{2, 9'h016, 1'b0, 1'b1, BIT_NS,        9'h016, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{2, 9'h015, 1'b0, 1'b0, BIT_NS,        9'h015, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{3, 9'h1A5, 1'b0, 1'b1, BIT_NS,        9'h1A5, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{3, 9'h0FF, 1'b1, 1'b1, BIT_NS,        9'h0FF, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{3, 9'h100, 1'b0, 1'b1, BIT_NS,        9'h100, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        for (int d = 0; d < 4; d++) begin
            rxLine[d] = 1'b1;
            mReady[d] = 1'b1;
            ovrClr[d] = 1'b0;
        end
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            checkOutput($sformatf("reset dut%0d valid", d),   32'(mValid[d]),  32'd0);
            checkOutput($sformatf("reset dut%0d busy", d),    32'(busy[d]),    32'd0);
            checkOutput($sformatf("reset dut%0d overrun", d), 32'(overrun[d]), 32'd0);
            checkOutput($sformatf("reset dut%0d data", d),    32'(getData(d)), 32'd0);
            checkOutput($sformatf("reset dut%0d flags", d),   32'({mPerr[d], mFerr[d], mBrk[d]}), 32'd0);
        end

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i]);
            checkFrame($sformatf("vec%0d", i), vecs[i].dut, vecs[i].expData,
                       vecs[i].expPerr, vecs[i].expFerr, vecs[i].expBrk);
        end
        checkOutput("valid pulse width", 32'(maxRun0), 32'd1);

        // Break: line held low for 30 bit-times yields one word and busy until the line rises.
        setRx(1, 1'b0);
        #(20.0 * BIT_NS);
        @(posedge clk);
        #1;
        checkOutput("break busy while low", 32'(busy[1]), 32'd1);
        checkOutput("break words while low", 32'(qSize(1)), 32'd1);
        #(10.0 * BIT_NS);
        setRx(1, 1'b1);
        #(2.0 * BIT_NS);
        @(posedge clk);
        #1;
        checkOutput("break busy after rise", 32'(busy[1]), 32'd0);
        checkFrame("break", 1, 9'h000, 1'b0, 1'b1, 1'b1);
        sendFrame(1, 9'h03C, 1'b0, 1'b1, BIT_NS);
        #(2.0 * BIT_NS);
        checkFrame("after break", 1, 9'h03C, 1'b0, 1'b0, 1'b0);

        // Short low glitch: busy after exactly 3 edges, false start rejected, no word.
        @(posedge clk);
        #1;
        setRx(0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("glitch busy after 2 edges", 32'(busy[0]), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("glitch busy after 3 edges", 32'(busy[0]), 32'd1);
        repeat (13) @(posedge clk);
        #1;
        setRx(0, 1'b1);
        repeat (30) @(posedge clk);
        #1;
        checkOutput("glitch busy released", 32'(busy[0]), 32'd0);
        #(2.0 * BIT_NS);
        checkOutput("glitch no output", 32'(qSize(0)), 32'd0);

        // Overrun with the consumer stalled, then accept and clear.
        mReady[0] = 1'b0;
        sendFrame(0, 9'h011, 1'b0, 1'b1, BIT_NS);
        #(2.0 * BIT_NS);
        sendFrame(0, 9'h022, 1'b0, 1'b1, BIT_NS);
        #(2.0 * BIT_NS);
        @(posedge clk);
        #1;
        checkOutput("ovr valid held", 32'(mValid[0]), 32'd1);
        checkOutput("ovr data held", 32'(mData0), 32'h11);
        checkOutput("ovr flag set", 32'(overrun[0]), 32'd1);
        checkOutput("ovr nothing accepted", 32'(qSize(0)), 32'd0);
        mReady[0] = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("ovr valid after accept", 32'(mValid[0]), 32'd0);
        checkOutput("ovr flag sticky", 32'(overrun[0]), 32'd1);
        checkFrame("ovr accepted", 0, 9'h011, 1'b0, 1'b0, 1'b0);
        ovrClr[0] = 1'b1;
        @(posedge clk);
        #1;
        ovrClr[0] = 1'b0;
        checkOutput("ovr cleared", 32'(overrun[0]), 32'd0);

        resetMidFrame("rst 8N1", 0, 9'h096);
        resetMidFrame("rst 5N2", 2, 9'h016);
        resetMidFrame("rst 9O1", 3, 9'h096);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
